// File: rtl/fp_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_mul_iter                                                |
// | Description : Parametrised IEEE-754 multiplier with an iterative         |
// |               shift-add mantissa datapath, full subnormal support,       |
// |               round-to-nearest-even and exception flags.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports (W = 1+EXP_W+MAN_W)                                                |
// |   i_clk    in   1  clock, rising edge                                    |
// |   i_rst    in   1  asynchronous active-high reset                        |
// |   i_valid  in   1  operands i_a/i_b valid                                |
// |   o_ready  out  1  block idle, operands accepted on i_valid&&o_ready     |
// |   i_a      in   W  operand A                                            |
// |   i_b      in   W  operand B                                            |
// |   o_valid  out  1  o_res/o_flags valid, held until i_ready               |
// |   i_ready  in   1  consumer accepts the result                           |
// |   o_res    out  W  product                                              |
// |   o_flags  out  4  {invalid, overflow, underflow, inexact}               |
// +--------------------------------------------------------------------------+
module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [EXP_W+MAN_W:0]   o_res,
  output logic [3:0]             o_flags
);

  localparam int M  = MAN_W + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * M;              // product register width
  localparam int XW = EXP_W + 2;          // signed working exponent width
  localparam int CW = $clog2(MAN_W + 4);  // iteration / shift counter width

  localparam logic signed [XW-1:0] C_BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] C_EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] C_ONE  = XW'(1);
  localparam logic [CW-1:0] C_MULT_LAST   = CW'(M - 1);
  localparam logic [CW-1:0] C_SHIFT_LIMIT = CW'(MAN_W + 3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [EXP_W+MAN_W:0]    a_q, a_d, b_q, b_d;
  logic [EXP_W+MAN_W:0]    res_q, res_d;
  logic [3:0]              flags_q, flags_d;
  logic                    sign_q, sign_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic [M-1:0]            mcand_q, mcand_d;
  logic [PW-1:0]           prod_q, prod_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  // Operand classification
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic [M-1:0]            fa, fb;
  logic signed [XW-1:0]    xa, xb, exp_sum;
  logic                    sign_ab;

  always_comb begin
    ea      = a_q[MAN_W +: EXP_W];
    eb      = b_q[MAN_W +: EXP_W];
    ma      = a_q[MAN_W-1:0];
    mb      = b_q[MAN_W-1:0];
    a_nan   = (&ea) & (|ma);
    a_inf   = (&ea) & ~(|ma);
    a_zero  = ~(|ea) & ~(|ma);
    b_nan   = (&eb) & (|mb);
    b_inf   = (&eb) & ~(|mb);
    b_zero  = ~(|eb) & ~(|mb);
    // Subnormals have a clear hidden bit and behave as if their exponent were 1.
    fa      = {|ea, ma};
    fb      = {|eb, mb};
    xa      = (|ea) ? {2'b00, ea} : C_ONE;
    xb      = (|eb) ? {2'b00, eb} : C_ONE;
    exp_sum = xa + xb - C_BIAS;
    sign_ab = a_q[EXP_W+MAN_W] ^ b_q[EXP_W+MAN_W];
  end

  // One shift-add step: the multiplier sits in the low half of prod_q and is
  // consumed LSB first while partial sums enter from the top.
  logic [M:0] add_hi;
  always_comb begin
    add_hi = {1'b0, prod_q[PW-1:M]};
    if (prod_q[0]) begin
      add_hi = {1'b0, prod_q[PW-1:M]} + {1'b0, mcand_q};
    end
  end

  // Rounding. The significand occupies prod_q[PW-2:M-1]; bit M-2 is the guard
  // bit and everything below folds into sticky. Right shifts during NORM jam
  // into bit 0, which lies within the sticky field.
  logic [M-1:0]         rnd_m;
  logic                 rnd_g, rnd_s, rnd_inc, rnd_carry, rnd_lead;
  logic [M:0]           rnd_sum;
  logic signed [XW-1:0] rnd_exp;
  logic [EXP_W+MAN_W:0] rnd_res;
  logic [3:0]           rnd_flags;

  always_comb begin
    rnd_m     = prod_q[PW-2:M-1];
    rnd_g     = prod_q[M-2];
    rnd_s     = |prod_q[M-3:0];
    rnd_inc   = rnd_g & (rnd_s | rnd_m[0]);
    rnd_sum   = {1'b0, rnd_m} + {{M{1'b0}}, rnd_inc};
    rnd_carry = rnd_sum[M];
    rnd_exp   = rnd_carry ? (exp_q + C_ONE) : exp_q;
    // A carry leaves 1.000..0 (stored bits already zero in rnd_sum).
    rnd_lead  = rnd_carry | rnd_sum[M-1];
    rnd_res   = '0;
    rnd_flags = '0;
    if (rnd_exp >= C_EMAX) begin
      rnd_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (rnd_lead) begin
      rnd_res   = {sign_q, rnd_exp[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
      rnd_flags = {3'b000, rnd_g | rnd_s};
    end else begin
      // Tiny result: subnormal or zero encoding.
      rnd_res   = {sign_q, {EXP_W{1'b0}}, rnd_sum[MAN_W-1:0]};
      rnd_flags = {2'b00, rnd_g | rnd_s, rnd_g | rnd_s};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d  = sign_ab;
        exp_d   = exp_sum;
        mcand_d = fa;
        prod_d  = {{M{1'b0}}, fb};
        cnt_d   = '0;
        state_d = S_MULT;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
          res_d   = '1;
          flags_d = 4'b1000;
          state_d = S_DONE;
        end else if (a_inf | b_inf) begin
          res_d   = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0000;
          state_d = S_DONE;
        end else if (a_zero | b_zero) begin
          res_d   = {sign_ab, {(EXP_W+MAN_W){1'b0}}};
          flags_d = 4'b0000;
          state_d = S_DONE;
        end
      end
      S_MULT: begin
        prod_d = {add_hi, prod_q[M-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == C_MULT_LAST) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (prod_q[PW-1]) begin
          prod_d = {1'b0, prod_q[PW-1:2], prod_q[1] | prod_q[0]};
          exp_d  = exp_q + C_ONE;
        end else if (!prod_q[PW-2] && (exp_q > C_ONE)) begin
          prod_d = {prod_q[PW-2:0], 1'b0};
          exp_d  = exp_q - C_ONE;
        end else if ((exp_q < C_ONE) && (cnt_q < C_SHIFT_LIMIT)) begin
          // Denormalise toward exponent 1; beyond the limit the value is
          // below a quarter ulp of the smallest subnormal and rounds to zero.
          prod_d = {1'b0, prod_q[PW-1:2], prod_q[1] | prod_q[0]};
          exp_d  = exp_q + C_ONE;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_d   = rnd_res;
        flags_d = rnd_flags;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_res   = res_q;
  assign o_flags = flags_q;

endmodule
`default_nettype wire
